// File: rtl/mul_pkg.sv
// Shared types and constants for the time-multiplexed multiplier scheduler.
package mul_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, MUL0 = 2'd1, MUL1 = 2'd2} state_t;

    localparam int DEF_W    = 4;
    localparam int DEF_NREQ = 4;

    function automatic int res_width(input int w);
        return 2 * w + 1;
    endfunction
endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: first valid requester at or after ptr, wrapping at NREQ-1.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            en,
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gidx
);
    logic           found;
    logic [IDW:0]   j;
    logic [IDW-1:0] idx;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        j     = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr + k stays below 2*NREQ, so a single subtract wraps it
            j = {1'b0, ptr} + (IDW+1)'(k);
            if (j >= (IDW+1)'(NREQ))
                j = j - (IDW+1)'(NREQ);
            idx = j[IDW-1:0];
            if (en && !found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end
endmodule

// File: rtl/mul_share_sched.sv
// Shares one WxW multiplier among NREQ requesters; each request yields a0*b0 + a1*b1.
module mul_share_sched
    import mul_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a0,
    input  logic [NREQ*W-1:0] req_b0,
    input  logic [NREQ*W-1:0] req_a1,
    input  logic [NREQ*W-1:0] req_b1,
    output logic              dout_en,
    output logic [2*W:0]      dout,
    output logic [IDW-1:0]    dout_id,
    output logic              busy
);
    localparam int RW = res_width(W);

    state_t          state, state_nxt;
    logic [IDW-1:0]  ptr, gidx, id_q;
    logic [NREQ-1:0] grant;
    logic            arb_en, accept, sel_lat;
    logic [W-1:0]    a1_q, b1_q, mul_a, mul_b;
    logic [2*W-1:0]  p0, prod;
    logic [RW-1:0]   acc;

    rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .en    (arb_en),
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .gidx  (gidx)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = accept ? MUL0 : IDLE;
            MUL0:    state_nxt = MUL1;
            MUL1:    state_nxt = accept ? MUL0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        arb_en  = (state == IDLE) || (state == MUL1);
        sel_lat = (state == MUL0);
        busy    = (state != IDLE);
    end

    // Accept cycle multiplies the requester's first pair; MUL0 reuses it for the latched second pair
    always_comb begin
        mul_a = sel_lat ? a1_q : req_a0[gidx*W +: W];
        mul_b = sel_lat ? b1_q : req_b0[gidx*W +: W];
        prod  = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr     <= '0;
            a1_q    <= '0;
            b1_q    <= '0;
            id_q    <= '0;
            p0      <= '0;
            acc     <= '0;
            dout    <= '0;
            dout_id <= '0;
            dout_en <= 1'b0;
        end else begin
            dout_en <= (state == MUL1);
            if (accept) begin
                a1_q <= req_a1[gidx*W +: W];
                b1_q <= req_b1[gidx*W +: W];
                id_q <= gidx;
                p0   <= prod;
                ptr  <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + IDW'(1);
            end
            if (state == MUL0)
                acc <= RW'(p0) + RW'(prod);
            // id_q may be overwritten by a back-to-back accept on this edge; old value is sampled
            if (state == MUL1) begin
                dout    <= acc;
                dout_id <= id_q;
            end
        end
    end
endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched: latency, arbitration order, reset abort, withdrawal.
module tb_mul_share_sched;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic              dout_en;
    logic [2*W:0]      dout;
    logic [IDW-1:0]    dout_id;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int exp4 [4] = '{47, 62, 77, 92};

    mul_share_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .dout_en   (dout_en),
        .dout      (dout),
        .dout_id   (dout_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int d, input int id);
        chk({tag, "_en"}, 32'(dout_en), 32'd1);
        chk({tag, "_dout"}, 32'(dout), 32'(d));
        chk({tag, "_id"}, 32'(dout_id), 32'(id));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1);
        req_a0[i*W +: W] = a0;
        req_b0[i*W +: W] = b0;
        req_a1[i*W +: W] = a1;
        req_b1[i*W +: W] = b1;
    endtask

    initial begin
        rstn = 1'b0;
        req_valid = '0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        tick(); tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_en", 32'(dout_en), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_id", 32'(dout_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        tick();

        // single request from 0: 1*15 + 2*14 = 43
        set_ops(0, 4'd1, 4'd15, 4'd2, 4'd14);
        req_valid = 4'b0001;
        #1 chk("t1_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_en0", 32'(dout_en), 32'd0);
        tick();
        chk("t1_en1", 32'(dout_en), 32'd0);
        tick();
        chk_out("t1", 43, 0);
        chk("t1_busy_lo", 32'(busy), 32'd0);
        tick();
        chk("t1_pulse", 32'(dout_en), 32'd0);
        chk("t1_hold", 32'(dout), 32'd43);

        // max operands from 3 (ptr=1 now)
        set_ops(3, 4'd15, 4'd15, 4'd15, 4'd15);
        req_valid = 4'b1000;
        #1 chk("t2_ready", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        tick(); tick();
        chk_out("t2", 450, 3);

        // reset, then 0 and 2 together
        tick();
        rstn = 1'b0;
        tick();
        chk("t3_rst_dout", 32'(dout), 32'd0);
        rstn = 1'b1;
        set_ops(0, 4'd3, 4'd4, 4'd5, 4'd6);
        set_ops(2, 4'd7, 4'd8, 4'd1, 4'd2);
        req_valid = 4'b0101;
        #1 chk("t3_ready0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0100;
        #1 chk("t3_ready_mul0", 32'(req_ready), 32'd0);
        tick();
        chk("t3_ready2", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        chk_out("t3a", 42, 0);
        tick();
        chk("t3_gap", 32'(dout_en), 32'd0);
        tick();
        chk_out("t3b", 58, 2);

        // all four held valid for 10 requests, starting from ptr=0
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < NREQ; i++)
            set_ops(i, W'(i+1), W'(i+2), W'(i+3), W'(15-i));
        req_valid = 4'hF;
        tick(); tick(); tick();
        for (int k = 0; k < 10; k++) begin
            if (k == 8) req_valid = '0;
            chk_out($sformatf("t4_r%0d", k), exp4[k%4], k%4);
            tick();
            chk($sformatf("t4_gap%0d", k), 32'(dout_en), 32'd0);
            tick();
        end
        chk("t4_idle", 32'(busy), 32'd0);

        // reset one cycle after accept (ptr=2)
        set_ops(3, 4'd2, 4'd2, 4'd2, 4'd2);
        set_ops(1, 4'd1, 4'd1, 4'd1, 4'd1);
        req_valid = 4'b1000;
        #1 chk("t5_ready3", 32'(req_ready), 32'b1000);
        tick();
        rstn = 1'b0;
        req_valid = 4'b1010;
        #1 chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_en_rst", 32'(dout_en), 32'd0);
        tick();
        rstn = 1'b1;
        #1 chk("t5_ready_low", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        chk("t5_en_a", 32'(dout_en), 32'd0);
        tick();
        chk("t5_en_b", 32'(dout_en), 32'd0);
        tick();
        chk_out("t5", 2, 1);

        // withdrawal by 1 while 0 served (ptr=2)
        tick();
        set_ops(0, 4'd2, 4'd3, 4'd4, 4'd5);
        req_valid = 4'b0001;
        #1 chk("t6_ready0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0010;
        #1 chk("t6_ready_mul0", 32'(req_ready), 32'd0);
        tick();
        req_valid = '0;
        #1 chk("t6_ready_wd", 32'(req_ready), 32'd0);
        tick();
        chk_out("t6a", 26, 0);
        tick();
        chk("t6_no_res", 32'(dout_en), 32'd0);
        set_ops(1, 4'd9, 4'd9, 4'd0, 4'd0);
        req_valid = 4'b0011;
        #1 chk("t6_ptr", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        chk("t6_en_a", 32'(dout_en), 32'd0);
        tick();
        chk("t6_en_b", 32'(dout_en), 32'd0);
        tick();
        chk_out("t6b", 81, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
